// File: rtl/icache_pkg.sv
// Shared constants, state encodings and address field helpers for the icache controller.
package icache_pkg;

  localparam int SETS        = 16;
  localparam int LINE_BITS   = 256;
  localparam int TAG_BITS    = 23;
  localparam int BEAT_BITS   = 64;
  localparam int BEATS       = LINE_BITS / BEAT_BITS;
  localparam int OFFSET_BITS = 5;
  localparam int INDEX_BITS  = 4;
  localparam int WORD_BITS   = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOOKUP = 2'd1;
  localparam state_t ST_FILL   = 2'd2;
  localparam state_t ST_WRITE  = 2'd3;

  function automatic logic [TAG_BITS-1:0] get_tag(input logic [31:0] addr);
    return TAG_BITS'(addr >> (OFFSET_BITS + INDEX_BITS));
  endfunction

  function automatic logic [INDEX_BITS-1:0] get_set(input logic [31:0] addr);
    return INDEX_BITS'(addr >> OFFSET_BITS);
  endfunction

  function automatic logic [WORD_BITS-1:0] get_word(input logic [31:0] addr);
    return WORD_BITS'(addr >> 2);
  endfunction

  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [WORD_BITS-1:0] idx);
    return line[{idx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/icache_fill_buffer.sv
// Assembles four memory beats into one cache line; done pulses with the final beat.
module icache_fill_buffer
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat_vld,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic                 done,
  output logic [LINE_BITS-1:0] line
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (beat_vld) cnt_q <= cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (beat_vld) line[{cnt_q, 6'd0} +: BEAT_BITS] <= beat_data;
  end

  assign done = beat_vld && (cnt_q == 2'(BEATS - 1));

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped icache controller: tag/data SRAM lookup, 4-beat line fill, flush.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ufp_req,
  input  logic [31:0]          ufp_addr,
  output logic                 ufp_ready,
  output logic                 ufp_resp,
  output logic [31:0]          ufp_rdata,
  input  logic                 flush,
  output logic                 dfp_read,
  output logic [31:0]          dfp_addr,
  input  logic                 dfp_rvalid,
  input  logic [BEAT_BITS-1:0] dfp_rdata,
  output logic                 data_csb,
  output logic                 data_web,
  output logic [31:0]          data_wmask,
  output logic [3:0]           data_addr,
  output logic [LINE_BITS-1:0] data_din,
  input  logic [LINE_BITS-1:0] data_dout,
  output logic                 tag_csb,
  output logic                 tag_web,
  output logic [3:0]           tag_addr,
  output logic [TAG_BITS-1:0]  tag_din,
`ifdef ICACHE_PERF_EN
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses,
`endif
  input  logic [TAG_BITS-1:0]  tag_dout
);

  state_t               state_q, state_d;
  logic [SETS-1:0]      valid_q;
  logic [31:0]          addr_q;
  logic                 flushed_q;
  logic                 hit, issue, fill_en, fill_done;
  logic [LINE_BITS-1:0] line_buf;

  // SRAM read data for addr_q is valid in LOOKUP, so the compare is purely combinational.
  assign hit     = valid_q[get_set(addr_q)] && (tag_dout == get_tag(addr_q));
  assign fill_en = (state_q == ST_FILL) && dfp_rvalid;

  icache_fill_buffer u_fill (
    .clk       (clk),
    .rst       (rst),
    .beat_vld  (fill_en),
    .beat_data (dfp_rdata),
    .done      (fill_done),
    .line      (line_buf)
  );

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    ufp_ready  = 1'b0;
    ufp_resp   = 1'b0;
    ufp_rdata  = '0;
    dfp_read   = 1'b0;
    dfp_addr   = '0;
    data_csb   = 1'b1;
    data_web   = 1'b1;
    data_wmask = '0;
    data_addr  = '0;
    data_din   = '0;
    tag_csb    = 1'b1;
    tag_web    = 1'b1;
    tag_addr   = '0;
    tag_din    = '0;
    case (state_q)
      ST_IDLE: begin
        ufp_ready = 1'b1;
        if (ufp_req) begin
          issue   = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          ufp_resp  = 1'b1;
          ufp_rdata = line_word(data_dout, get_word(addr_q));
          ufp_ready = 1'b1;
          issue     = ufp_req;
          state_d   = ufp_req ? ST_LOOKUP : ST_IDLE;
        end else begin
          dfp_read = 1'b1;
          dfp_addr = {addr_q[31:5], 5'd0};
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        dfp_read = 1'b1;
        dfp_addr = {addr_q[31:5], 5'd0};
        if (fill_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        data_csb   = 1'b0;
        data_web   = 1'b0;
        data_wmask = '1;
        data_addr  = get_set(addr_q);
        data_din   = line_buf;
        tag_csb    = 1'b0;
        tag_web    = 1'b0;
        tag_addr   = get_set(addr_q);
        tag_din    = get_tag(addr_q);
        ufp_resp   = 1'b1;
        ufp_rdata  = line_word(line_buf, get_word(addr_q));
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      data_csb  = 1'b0;
      data_addr = get_set(ufp_addr);
      tag_csb   = 1'b0;
      tag_addr  = get_set(ufp_addr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // A flush anywhere from the miss compare through WRITE leaves the new line invalid.
      if (state_q == ST_LOOKUP && !hit) flushed_q <= flush;
      else if (state_q == ST_FILL && flush) flushed_q <= 1'b1;
      if (flush) valid_q <= '0;
      else if (state_q == ST_WRITE && !flushed_q) valid_q[get_set(addr_q)] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) addr_q <= ufp_addr;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (hit && perf_hits != '1) perf_hits <= perf_hits + 32'd1;
      if (!hit && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized self-checking bench for icache_ctrl with SRAM, memory and cache-contents models.
`timescale 1ns/1ps
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         ufp_req;
  logic [31:0]  ufp_addr;
  logic         ufp_ready, ufp_resp;
  logic [31:0]  ufp_rdata;
  logic         flush;
  logic         dfp_read;
  logic [31:0]  dfp_addr;
  logic         dfp_rvalid;
  logic [63:0]  dfp_rdata;
  logic         data_csb, data_web;
  logic [31:0]  data_wmask;
  logic [3:0]   data_addr;
  logic [255:0] data_din, data_dout;
  logic         tag_csb, tag_web;
  logic [3:0]   tag_addr;
  logic [22:0]  tag_din, tag_dout;
`ifdef ICACHE_PERF_EN
  logic [31:0]  perf_hits, perf_misses;
`endif

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ufp_req    (ufp_req),
    .ufp_addr   (ufp_addr),
    .ufp_ready  (ufp_ready),
    .ufp_resp   (ufp_resp),
    .ufp_rdata  (ufp_rdata),
    .flush      (flush),
    .dfp_read   (dfp_read),
    .dfp_addr   (dfp_addr),
    .dfp_rvalid (dfp_rvalid),
    .dfp_rdata  (dfp_rdata),
    .data_csb   (data_csb),
    .data_web   (data_web),
    .data_wmask (data_wmask),
    .data_addr  (data_addr),
    .data_din   (data_din),
    .data_dout  (data_dout),
    .tag_csb    (tag_csb),
    .tag_web    (tag_web),
    .tag_addr   (tag_addr),
    .tag_din    (tag_din),
`ifdef ICACHE_PERF_EN
    .perf_hits  (perf_hits),
    .perf_misses(perf_misses),
`endif
    .tag_dout   (tag_dout)
  );

  // SRAM macros: registered read, write lands at the sampling edge.
  logic [255:0] dmem [16];
  logic [22:0]  tmem [16];

  always @(posedge clk) begin
    if (!data_csb) begin
      if (!data_web) begin
        for (int b = 0; b < 32; b++)
          if (data_wmask[b]) dmem[data_addr][b*8 +: 8] <= data_din[b*8 +: 8];
      end else begin
        data_dout <= dmem[data_addr];
      end
    end
    if (!tag_csb) begin
      if (!tag_web) tmem[tag_addr] <= tag_din;
      else tag_dout <= tmem[tag_addr];
    end
  end

  // Backing memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word({a[31:5], 5'd0} + 32'(i * 4));
    return l;
  endfunction

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          acc;
  } req_t;

  req_t        expq[$];
  logic [31:0] stim[$];
  int          rc[$];
  bit          mv [16];
  logic [22:0] mt [16];
  int          n_chk, n_pass, cyc;
  int          gap_pct, flush_pct, stray_pct, flush_at_beat;
  bit          mem_active, hold_chk, prev_dfp, fl_since, dfp_seen;
  int          bcnt, last_beat_cyc;
  logic [31:0] mem_addr, last_dfp_addr;
  int          n_dfp, n_resp, n_dwr;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  task automatic step();
    bit           beat_now, acc, q_empty, wr, exp_wr;
    logic [255:0] ln;
    logic [3:0]   s;
    req_t         h;
    @(negedge clk);
    cyc++;
    beat_now = 1'b0;
    if (stim.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      ufp_req  = 1'b1;
      ufp_addr = stim[0] | 32'($urandom_range(0, 3));
    end else begin
      ufp_req  = 1'b0;
      ufp_addr = $urandom;
    end
    flush      = ($urandom_range(0, 99) < flush_pct);
    dfp_rvalid = 1'b0;
    dfp_rdata  = {$urandom, $urandom};
    if (mem_active && $urandom_range(0, 2) != 0) begin
      ln         = mem_line(mem_addr);
      dfp_rvalid = 1'b1;
      dfp_rdata  = ln[bcnt*64 +: 64];
      if (bcnt == flush_at_beat) flush = 1'b1;
      bcnt++;
      beat_now = 1'b1;
    end else if (!mem_active && $urandom_range(0, 99) < stray_pct) begin
      dfp_rvalid = 1'b1;
    end
    #1;
    q_empty = (expq.size() == 0);
    if (q_empty) chk("ready_idle", 256'(ufp_ready), 256'(1));
    if (dfp_read) begin
      if (q_empty) chk("dfp_read_idle", 256'(dfp_read), 256'(0));
      else begin
        chk("dfp_addr", 256'(dfp_addr), 256'({expq[0].addr[31:5], 5'd0}));
        dfp_seen = 1'b1;
      end
      last_dfp_addr = dfp_addr;
      if (!prev_dfp) begin
        n_dfp++;
        mem_active = 1'b1;
        hold_chk   = 1'b1;
        bcnt       = 0;
        mem_addr   = dfp_addr;
      end
    end
    if (mem_active && hold_chk) chk("dfp_hold", 256'(dfp_read), 256'(1));
    if (beat_now && bcnt == 4) begin
      mem_active    = 1'b0;
      last_beat_cyc = cyc;
    end
    wr     = !data_csb && !data_web;
    exp_wr = ufp_resp && !q_empty && !expq[0].hit;
    chk("data_wr", 256'(wr), 256'(exp_wr));
    chk("tag_wr", 256'(!tag_csb && !tag_web), 256'(exp_wr));
    if (wr) begin
      n_dwr++;
      if (!q_empty) begin
        chk("wr_line", data_din, mem_line(expq[0].addr));
        chk("wr_mask", 256'(data_wmask), 256'(32'hFFFF_FFFF));
        chk("wr_set", 256'(data_addr), 256'(expq[0].addr[8:5]));
        chk("wr_tag_set", 256'(tag_addr), 256'(expq[0].addr[8:5]));
        chk("wr_tag", 256'(tag_din), 256'(expq[0].addr[31:9]));
      end
    end
    if (!q_empty && expq[0].hit && cyc == expq[0].acc + 1) begin
      chk("hit_resp", 256'(ufp_resp), 256'(1));
      chk("hit_ready", 256'(ufp_ready), 256'(1));
    end
    if (ufp_resp) begin
      n_resp++;
      rc.push_back(cyc);
      if (q_empty) chk("spurious_resp", 256'(ufp_resp), 256'(0));
      else begin
        h = expq.pop_front();
        s = h.addr[8:5];
        chk("rdata", 256'(ufp_rdata), 256'(mem_word(h.addr)));
        chk("miss", 256'(dfp_seen), 256'(!h.hit));
        if (!h.hit) begin
          chk("miss_lat", 256'(cyc), 256'(last_beat_cyc + 1));
          if (!fl_since && !flush) begin
            mv[s] = 1'b1;
            mt[s] = h.addr[31:9];
          end
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      if (expq.size() > 0) fl_since = 1'b1;
    end
    acc = ufp_req && ufp_ready;
    if (acc) begin
      if (expq.size() > 0) chk("accept_busy", 256'(expq.size()), 256'(0));
      s = ufp_addr[8:5];
      void'(stim.pop_front());
      expq.push_back('{addr: ufp_addr, hit: (mv[s] && mt[s] == ufp_addr[31:9]), acc: cyc});
      fl_since = 1'b0;
      dfp_seen = 1'b0;
    end
    prev_dfp = dfp_read;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((stim.size() > 0 || expq.size() > 0 || mem_active) && n < budget) begin
      step();
      n++;
    end
    chk("drain", 256'(stim.size() == 0 && expq.size() == 0 && !mem_active), 256'(1));
  endtask

  initial begin
    int n0, d0, r0, n;
    rst = 1'b1; ufp_req = 1'b0; ufp_addr = '0; flush = 1'b0;
    dfp_rvalid = 1'b0; dfp_rdata = '0; data_dout = '0; tag_dout = '0;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = '0; tmem[i] = '0; mv[i] = 1'b0; mt[i] = '0;
    end
    n_chk = 0; n_pass = 0; cyc = 0; n_dfp = 0; n_resp = 0; n_dwr = 0;
    mem_active = 1'b0; hold_chk = 1'b0; prev_dfp = 1'b0; fl_since = 1'b0; dfp_seen = 1'b0;
    bcnt = 0; last_beat_cyc = -10; mem_addr = '0; last_dfp_addr = '0;
    gap_pct = 0; flush_pct = 0; stray_pct = 0; flush_at_beat = -1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 256'(ufp_ready), 256'(1));
    chk("rst_resp", 256'(ufp_resp), 256'(0));
    chk("rst_rdata", 256'(ufp_rdata), 256'(0));
    chk("rst_dfp_read", 256'(dfp_read), 256'(0));
    chk("rst_dfp_addr", 256'(dfp_addr), 256'(0));
    chk("rst_sram_ctl", 256'({data_csb, data_web, tag_csb, tag_web}), 256'(4'hF));
    chk("rst_wmask", 256'(data_wmask), 256'(0));
    chk("rst_din", data_din, 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // Cold miss
    n0 = n_dwr; d0 = n_dfp;
    stim.push_back(32'h0000_1004);
    run(100);
    chk("cold_dwr", 256'(n_dwr - n0), 256'(1));
    chk("cold_dfp", 256'(n_dfp - d0), 256'(1));
    chk("cold_addr", 256'(last_dfp_addr), 256'(32'h0000_1000));

    // Hit streak, back-to-back
    d0 = n_dfp; r0 = n_resp;
    stim.push_back(32'h0000_1000); stim.push_back(32'h0000_1004); stim.push_back(32'h0000_1008);
    run(50);
    chk("streak_resps", 256'(n_resp - r0), 256'(3));
    chk("streak_nodfp", 256'(n_dfp - d0), 256'(0));
    chk("streak_b2b", 256'(rc[rc.size()-1] - rc[rc.size()-3]), 256'(2));
`ifdef ICACHE_PERF_EN
    chk("perf_misses", 256'(perf_misses), 256'(1));
    chk("perf_hits", 256'(perf_hits), 256'(3));
`endif

    // Conflict on set 0
    d0 = n_dfp;
    stim.push_back(32'h0000_3000); run(100);
    stim.push_back(32'h0000_1000); run(100);
    chk("conflict_dfp", 256'(n_dfp - d0), 256'(2));

    // Flush during fill: response returned, line left invalid
    d0 = n_dfp; r0 = n_resp;
    flush_at_beat = 2;
    stim.push_back(32'h0000_2048); run(100);
    flush_at_beat = -1;
    stim.push_back(32'h0000_2048); run(100);
    chk("flushfill_dfp", 256'(n_dfp - d0), 256'(2));
    chk("flushfill_resp", 256'(n_resp - r0), 256'(2));

    // Reset after beat 1 of a fill
    stim.push_back(32'h0000_4100);
    n = 0;
    while (!(mem_active && bcnt == 2) && n < 50) begin
      step();
      n++;
    end
    chk("rstfill_reach", 256'(bcnt), 256'(2));
    n0 = n_dwr; r0 = n_resp;
    @(negedge clk);
    cyc++;
    rst = 1'b1; ufp_req = 1'b0; dfp_rvalid = 1'b0; flush = 1'b0;
    #1;
    chk("rstfill_dfp", 256'(dfp_read), 256'(0));
    chk("rstfill_ready", 256'(ufp_ready), 256'(1));
    chk("rstfill_resp", 256'(ufp_resp), 256'(0));
    expq.delete();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    hold_chk = 1'b0; prev_dfp = 1'b0; fl_since = 1'b0; dfp_seen = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    run(50);
    chk("rstfill_nowr", 256'(n_dwr - n0), 256'(0));
    chk("rstfill_noresp", 256'(n_resp - r0), 256'(0));
    d0 = n_dfp;
    stim.push_back(32'h0000_1000); run(100);
    chk("rst_invalid", 256'(n_dfp - d0), 256'(1));

    // Randomized traffic with flushes and stray beats
    gap_pct = 30; flush_pct = 3; stray_pct = 15;
    for (int i = 0; i < 300; i++)
      stim.push_back((32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                     (32'($urandom_range(0, 7)) << 2));
    run(20000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
